// File: rtl/mul_div_unit.sv
// Iterative radix-2 multiply/divide unit with HI/LO result registers.
// Define MDU_EARLY_OUT_EN to let multiplies finish once the remaining multiplier bits are zero.
module mul_div_unit #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            kill,
    output logic            busy,
    output logic            done,
    output logic            div0,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    localparam int unsigned W2 = 2 * XLEN;

    typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [W2-1:0]     acc_q, acc_d;
    logic [W2-1:0]     mcand_q, mcand_d;
    logic [XLEN-1:0]   opb_q, opb_d;
    logic              is_mul_q, is_mul_d;
    logic              neg_q, neg_d;
    logic              rneg_q, rneg_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              div0_q, div0_d;
    logic [XLEN-1:0]   hi_q, hi_d;
    logic [XLEN-1:0]   lo_q, lo_d;

    logic              sgn_op;
    logic [XLEN-1:0]   a_abs, b_abs;
    logic [W2-1:0]     mul_add;
    logic [XLEN:0]     rem_sh, div_diff;
    logic [W2-1:0]     div_next;
    logic [W2-1:0]     prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix;
    logic              early_out;

    assign sgn_op = ~op[0];
    assign a_abs  = (sgn_op && a[XLEN-1]) ? -a : a;
    assign b_abs  = (sgn_op && b[XLEN-1]) ? -b : b;

    // Multiply: add the left-shifting multiplicand when the current multiplier LSB is set.
    assign mul_add = opb_q[0] ? mcand_q : '0;

    // Divide: acc holds {remainder, dividend/quotient}; restoring trial subtraction.
    assign rem_sh   = {acc_q[W2-1:XLEN], acc_q[XLEN-1]};
    assign div_diff = rem_sh - {1'b0, opb_q};
    assign div_next = div_diff[XLEN] ? {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                     : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

    assign prod_fix = neg_q ? -acc_q : acc_q;
    assign quo_fix  = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    assign rem_fix  = rneg_q ? -acc_q[W2-1:XLEN] : acc_q[W2-1:XLEN];

`ifdef MDU_EARLY_OUT_EN
    assign early_out = is_mul_q && ((opb_q >> 1) == '0);
`else
    assign early_out = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        opb_d    = opb_q;
        is_mul_d = is_mul_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        div0_d   = div0_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        unique case (state_q)
            StIdle: begin
                if (start && !kill) begin
                    if (op <= 3'd3) begin
                        state_d  = StRun;
                        busy_d   = 1'b1;
                        cnt_d    = CNT_W'(XLEN);
                        is_mul_d = ~op[1];
                        div0_d   = 1'b0;
                        opb_d    = b_abs;
                        if (!op[1]) begin
                            acc_d   = '0;
                            mcand_d = {{XLEN{1'b0}}, a_abs};
                            neg_d   = sgn_op && (a[XLEN-1] ^ b[XLEN-1]);
                            rneg_d  = 1'b0;
                        end else begin
                            acc_d   = {{XLEN{1'b0}}, a_abs};
                            mcand_d = '0;
                            // Divide by zero keeps the all-ones quotient unnegated.
                            neg_d   = sgn_op && (a[XLEN-1] ^ b[XLEN-1]) && (b != '0);
                            rneg_d  = sgn_op && a[XLEN-1];
                        end
                    end else if (op == 3'd4) begin
                        hi_d   = a;
                        done_d = 1'b1;
                        div0_d = 1'b0;
                    end else if (op == 3'd5) begin
                        lo_d   = a;
                        done_d = 1'b1;
                        div0_d = 1'b0;
                    end
                end
            end
            StRun: begin
                if (kill) begin
                    state_d = StIdle;
                    busy_d  = 1'b0;
                end else begin
                    if (is_mul_q) begin
                        acc_d   = acc_q + mul_add;
                        mcand_d = mcand_q << 1;
                        opb_d   = opb_q >> 1;
                    end else begin
                        acc_d = div_next;
                    end
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1) || early_out) begin
                        state_d = StFix;
                    end
                end
            end
            StFix: begin
                state_d = StIdle;
                busy_d  = 1'b0;
                if (!kill) begin
                    done_d = 1'b1;
                    if (is_mul_q) begin
                        hi_d = prod_fix[W2-1:XLEN];
                        lo_d = prod_fix[XLEN-1:0];
                    end else begin
                        hi_d   = rem_fix;
                        lo_d   = quo_fix;
                        div0_d = (opb_q == '0);
                    end
                end
            end
            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            opb_q    <= '0;
            is_mul_q <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            div0_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            opb_q    <= opb_d;
            is_mul_q <= is_mul_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            div0_q   <= div0_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign div0 = div0_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: vector table, random ops against an arithmetic model,
// and hand-written kill/reset/MTxx sequences.
module tb_mul_div_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        kill;
    logic        busy;
    logic        done;
    logic        div0;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks = 0;
    int n_fail   = 0;

    mul_div_unit #(.XLEN(32), .CNT_W(6)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .kill  (kill),
        .busy  (busy),
        .done  (done),
        .div0  (div0),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        logic        exp_div0;
    } vec_t;

    function automatic void check(input string nm, input logic [31:0] got,
                                  input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
        end
    endfunction

    // Reference results from plain integer arithmetic.
    function automatic void model(input logic [2:0] mop, input logic [31:0] ma,
                                  input logic [31:0] mb, output logic [31:0] mhi,
                                  output logic [31:0] mlo, output logic md0);
        longint      p;
        logic [63:0] up;
        int          sa;
        int          sb;
        sa  = ma;
        sb  = mb;
        md0 = 1'b0;
        mhi = '0;
        mlo = '0;
        case (mop)
            3'd0: begin
                p = longint'(sa) * longint'(sb);
                {mhi, mlo} = p;
            end
            3'd1: begin
                up = {32'b0, ma} * {32'b0, mb};
                {mhi, mlo} = up;
            end
            3'd2: begin
                if (mb == 0) begin
                    mlo = '1; mhi = ma; md0 = 1'b1;
                end else if (ma == 32'h8000_0000 && mb == 32'hFFFF_FFFF) begin
                    mlo = ma; mhi = '0;
                end else begin
                    mlo = sa / sb; mhi = sa % sb;
                end
            end
            3'd3: begin
                if (mb == 0) begin
                    mlo = '1; mhi = ma; md0 = 1'b1;
                end else begin
                    mlo = ma / mb; mhi = ma % mb;
                end
            end
            default: ;
        endcase
    endfunction

    // Edges from the accepting edge (inclusive) to the edge after which done is visible.
    function automatic int exp_lat(input logic [2:0] mop, input logic [31:0] mb);
        int top;
        logic [31:0] babs;
        top = -1;
`ifdef MDU_EARLY_OUT_EN
        if (mop <= 3'd1) begin
            babs = (mop == 3'd0 && mb[31]) ? -mb : mb;
            for (int i = 0; i < 32; i++) if (babs[i]) top = i;
            return (top < 0) ? 3 : top + 3;
        end
`else
        babs = mb;
        if (babs[0] && top > 0) return 0;
`endif
        return 34;
    endfunction

    task automatic run_op(input string nm, input logic [2:0] top_op, input logic [31:0] ta,
                          input logic [31:0] tb, input logic [31:0] ehi,
                          input logic [31:0] elo, input logic ed0);
        int lat;
        logic busy_ok;
        @(negedge clk);
        start = 1'b1; op = top_op; a = ta; b = tb;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        busy_ok = 1'b1;
        check({nm, " div0 cleared"}, 32'(div0), 0);
        while (!done && lat < 100) begin
            if (!busy) busy_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        check({nm, " latency"}, 32'(lat), 32'(exp_lat(top_op, tb)));
        check({nm, " busy held"}, 32'(busy_ok), 1);
        check({nm, " busy at done"}, 32'(busy), 0);
        check({nm, " hi"}, hi, ehi);
        check({nm, " lo"}, lo, elo);
        check({nm, " div0"}, 32'(div0), 32'(ed0));
    endtask

    vec_t tbl[10];

    initial begin
        logic [31:0] ehi, elo, rhi, rlo, ra, rb;
        logic        ed0, saw;
        logic [2:0]  rop;
        int          lat;

        tbl[0] = '{3'd0, 32'hFFFF_FFFD, 32'd7,          32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
        tbl[1] = '{3'd1, 32'hFFFF_FFFD, 32'd7,          32'h0000_0006, 32'hFFFF_FFEB, 1'b0};
        tbl[2] = '{3'd2, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        tbl[3] = '{3'd3, 32'd100,       32'd7,          32'd2,         32'd14,        1'b0};
        tbl[4] = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000, 1'b0};
        tbl[5] = '{3'd3, 32'd5,         32'd0,          32'd5,         32'hFFFF_FFFF, 1'b1};
        tbl[6] = '{3'd2, 32'hFFFF_FFFB, 32'd0,          32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1};
        tbl[7] = '{3'd2, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0};
        tbl[8] = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
        tbl[9] = '{3'd1, 32'h0123_4567, 32'd1,          32'h0,         32'h0123_4567, 1'b0};

        rst = 1'b0; start = 1'b0; kill = 1'b0; op = '0; a = '0; b = '0;
        #12;
        check("reset busy", 32'(busy), 0);
        check("reset done", 32'(done), 0);
        check("reset div0", 32'(div0), 0);
        check("reset hi", hi, 0);
        check("reset lo", lo, 0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b,
                   tbl[i].exp_hi, tbl[i].exp_lo, tbl[i].exp_div0);
        end
        @(posedge clk); #1;
        check("done single pulse", 32'(done), 0);

        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'h0;
                1: rb = 32'hFFFF_FFFF;
                2: ra = 32'h8000_0000;
                3: rb = 32'($urandom_range(1, 15));
                default: ;
            endcase
            model(rop, ra, rb, ehi, elo, ed0);
            run_op($sformatf("rnd%0d op%0d", i, rop), rop, ra, rb, ehi, elo, ed0);
        end

        // MTLO / MTHI: single-edge writes with a done pulse, never busy.
        rhi = hi;
        @(negedge clk);
        start = 1'b1; op = 3'd5; a = 32'h1234;
        @(posedge clk); #1;
        start = 1'b0;
        check("mtlo lo", lo, 32'h1234);
        check("mtlo hi kept", hi, rhi);
        check("mtlo done", 32'(done), 1);
        check("mtlo busy", 32'(busy), 0);
        @(posedge clk); #1;
        check("mtlo done drops", 32'(done), 0);
        @(negedge clk);
        start = 1'b1; op = 3'd4; a = 32'hCAFE_0001;
        @(posedge clk); #1;
        start = 1'b0;
        check("mthi hi", hi, 32'hCAFE_0001);
        check("mthi lo kept", lo, 32'h1234);
        check("mthi done", 32'(done), 1);

        // op 6 is ignored entirely.
        @(negedge clk);
        start = 1'b1; op = 3'd6; a = 32'h5555_5555;
        @(posedge clk); #1;
        start = 1'b0;
        check("op6 busy", 32'(busy), 0);
        check("op6 done", 32'(done), 0);
        check("op6 hi", hi, 32'hCAFE_0001);
        check("op6 lo", lo, 32'h1234);

        // kill in the same cycle as start blocks acceptance.
        @(negedge clk);
        start = 1'b1; kill = 1'b1; op = 3'd1; a = 32'd9; b = 32'd9;
        @(posedge clk); #1;
        start = 1'b0; kill = 1'b0;
        check("kill+start busy", 32'(busy), 0);

        // kill mid-run aborts: no done, hi/lo unchanged.
        @(negedge clk);
        start = 1'b1; op = 3'd0; a = 32'd9; b = 32'hFFFF_0003;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        check("kill busy drops", 32'(busy), 0);
        saw = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done) saw = 1'b1;
        end
        check("kill no done", 32'(saw), 0);
        check("kill hi kept", hi, 32'hCAFE_0001);
        check("kill lo kept", lo, 32'h1234);

        // start while busy is dropped; result belongs to the first op only.
        @(negedge clk);
        start = 1'b1; op = 3'd3; a = 32'd100; b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        repeat (3) begin
            @(posedge clk); #1;
            lat++;
        end
        @(negedge clk);
        start = 1'b1; op = 3'd0; a = 32'd3; b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        lat++;
        while (!done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check("busy-start latency", 32'(lat), 34);
        check("busy-start lo", lo, 32'd14);
        check("busy-start hi", hi, 32'd2);
        @(posedge clk); #2;
        check("busy-start not queued", 32'(busy), 0);

        // Async reset mid-run clears everything before the next edge.
        @(negedge clk);
        start = 1'b1; op = 3'd1; a = 32'd11; b = 32'd13;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("async rst busy", 32'(busy), 0);
        check("async rst done", 32'(done), 0);
        check("async rst hi", hi, 0);
        check("async rst lo", lo, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("post rst idle lo", lo, 0);

        run_op("after rst", 3'd1, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
